// File: rtl/csr_trap_sequencer.sv
// csr_trap_sequencer: machine-mode trap/MRET controller. Arbitrates
// exceptions > interrupts > MRET in IDLE, then writes mepc, mcause, mtval
// and mstatus (or mstatus only for MRET) one per cycle over the CSR write
// port, and ends with a one-cycle fetch redirect.
// Ports: clk_i/rst_i (async active-high); exc_*_i, next_pc_i, mret_i,
// irq_i requests; mstatus_i/mie_i/mtvec_i/mepc_i current CSR values;
// csr_we_o/csr_waddr_o/csr_wdata_o write port; busy_o stall, flush_o,
// redirect_o/redirect_pc_o to the front end.
// Optional macro CSR_TRAP_VECTORED_EN: vectored interrupt targets.
module csr_trap_sequencer #(
    parameter int CSR_ADDR_W = 12,
    parameter int XLEN       = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_cause_i,
    input  logic [XLEN-1:0]       exc_tval_i,
    input  logic [XLEN-1:0]       exc_pc_i,
    input  logic [XLEN-1:0]       next_pc_i,
    input  logic                  mret_i,
    input  logic [2:0]            irq_i,
    input  logic [XLEN-1:0]       mstatus_i,
    input  logic [XLEN-1:0]       mie_i,
    input  logic [XLEN-1:0]       mtvec_i,
    input  logic [XLEN-1:0]       mepc_i,
    output logic                  csr_we_o,
    output logic [CSR_ADDR_W-1:0] csr_waddr_o,
    output logic [XLEN-1:0]       csr_wdata_o,
    output logic                  busy_o,
    output logic                  flush_o,
    output logic                  redirect_o,
    output logic [XLEN-1:0]       redirect_pc_o
);

    typedef enum logic [2:0] {
        IDLE,
        WR_MEPC,
        WR_MCAUSE,
        WR_MTVAL,
        WR_MSTATUS,
        RET_MSTATUS,
        REDIRECT
    } state_t;

    state_t state, state_nxt;

    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] tval_q;
    logic            ret_q;

    logic [2:0]      irq_en;
    logic            int_en;
    logic [3:0]      irq_code;
    logic            take_exc;
    logic            take_irq;
    logic            take_ret;
    logic [XLEN-1:0] ms_trap;
    logic [XLEN-1:0] ms_ret;
    logic [XLEN-1:0] tgt_pc;

    // {MEI, MTI, MSI} pending and enabled
    assign irq_en = {irq_i[2] & mie_i[11],
                     irq_i[1] & mie_i[7],
                     irq_i[0] & mie_i[3]};
    assign int_en = mstatus_i[3] & (|irq_en);

    // Priority MEI > MSI > MTI
    always_comb begin
        irq_code = 4'd7;
        if (irq_en[2])
            irq_code = 4'd11;
        else if (irq_en[0])
            irq_code = 4'd3;
    end

    // Accepts are gated by reset so nothing leaks out while it is held
    assign take_exc = (state == IDLE) & ~rst_i & exc_valid_i;
    assign take_irq = (state == IDLE) & ~rst_i & ~exc_valid_i & int_en;
    assign take_ret = (state == IDLE) & ~rst_i & ~exc_valid_i & ~int_en
                      & mret_i;

    always_comb begin
        ms_trap        = mstatus_i;
        ms_trap[7]     = mstatus_i[3];
        ms_trap[3]     = 1'b0;
        ms_trap[12:11] = 2'b11;
    end

    always_comb begin
        ms_ret        = mstatus_i;
        ms_ret[3]     = mstatus_i[7];
        ms_ret[7]     = 1'b1;
        ms_ret[12:11] = 2'b11;
    end

    always_comb begin
        if (ret_q) begin
            tgt_pc = {mepc_i[XLEN-1:2], 2'b00};
        end else begin
            tgt_pc = {mtvec_i[XLEN-1:2], 2'b00};
`ifdef CSR_TRAP_VECTORED_EN
            if (cause_q[XLEN-1] && mtvec_i[1:0] == 2'b01)
                tgt_pc = tgt_pc + {{(XLEN-6){1'b0}}, cause_q[3:0], 2'b00};
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cause_q <= '0;
            epc_q   <= '0;
            tval_q  <= '0;
            ret_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take_exc) begin
                cause_q <= {27'b0, exc_cause_i};
                epc_q   <= {exc_pc_i[XLEN-1:2], 2'b00};
                tval_q  <= exc_tval_i;
                ret_q   <= 1'b0;
            end else if (take_irq) begin
                cause_q <= {1'b1, 27'b0, irq_code};
                epc_q   <= {next_pc_i[XLEN-1:2], 2'b00};
                tval_q  <= '0;
                ret_q   <= 1'b0;
            end else if (take_ret) begin
                ret_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        csr_we_o      = 1'b0;
        csr_waddr_o   = '0;
        csr_wdata_o   = '0;
        busy_o        = 1'b1;
        flush_o       = 1'b0;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        unique case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (take_exc || take_irq) begin
                    flush_o   = 1'b1;
                    busy_o    = 1'b1;
                    state_nxt = WR_MEPC;
                end else if (take_ret) begin
                    flush_o   = 1'b1;
                    busy_o    = 1'b1;
                    state_nxt = RET_MSTATUS;
                end
            end
            WR_MEPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_ADDR_W'(12'h341);
                csr_wdata_o = epc_q;
                state_nxt   = WR_MCAUSE;
            end
            WR_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_ADDR_W'(12'h342);
                csr_wdata_o = cause_q;
                state_nxt   = WR_MTVAL;
            end
            WR_MTVAL: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_ADDR_W'(12'h343);
                csr_wdata_o = tval_q;
                state_nxt   = WR_MSTATUS;
            end
            WR_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_ADDR_W'(12'h300);
                csr_wdata_o = ms_trap;
                state_nxt   = REDIRECT;
            end
            RET_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_ADDR_W'(12'h300);
                csr_wdata_o = ms_ret;
                state_nxt   = REDIRECT;
            end
            REDIRECT: begin
                redirect_o    = 1'b1;
                redirect_pc_o = tgt_pc;
                state_nxt     = IDLE;
            end
            default: begin
                busy_o    = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/csr_trap_sequencer.md
Name: csr_trap_sequencer

Overview:
- Machine-mode trap and return controller for the CSR file.
- Arbitrates between synchronous exceptions, pending interrupts and MRET.
- Sequences the required CSR updates (mepc, mcause, mtval, mstatus) over the single CSR write port, one register per cycle.
- Issues pipeline flush, stall and PC redirect to the core front end.

Parameters:
- CSR_ADDR_W, 12, width of CSR write address.
- XLEN, 32, register/PC width; only 32 is supported.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset, asynchronous, active-high
- exc_valid_i  in  1  synchronous exception from the retiring instruction
- exc_cause_i  in  5  exception code
- exc_tval_i  in  XLEN  trap value for the exception
- exc_pc_i  in  XLEN  PC of the faulting instruction
- next_pc_i  in  XLEN  PC of the next unretired instruction (interrupt mepc)
- mret_i  in  1  MRET retiring
- irq_i  in  3  {meip, mtip, msip} level-sensitive pending lines
- mstatus_i  in  XLEN  current mstatus
- mie_i  in  XLEN  current mie
- mtvec_i  in  XLEN  current mtvec
- mepc_i  in  XLEN  current mepc
- csr_we_o  out  1  CSR write strobe
- csr_waddr_o  out  CSR_ADDR_W  CSR write address
- csr_wdata_o  out  XLEN  CSR write data
- busy_o  out  1  stall request to the pipeline
- flush_o  out  1  one-cycle pipeline flush
- redirect_o  out  1  one-cycle fetch redirect strobe
- redirect_pc_o  out  XLEN  redirect target

Behaviour:
- Reset: state IDLE; csr_we_o, busy_o, flush_o and redirect_o are 0; csr_waddr_o, csr_wdata_o, redirect_pc_o and the internal latches are 0.
- States: IDLE, WR_MEPC, WR_MCAUSE, WR_MTVAL, WR_MSTATUS, RET_MSTATUS, REDIRECT.
- Interrupt eligibility: int_en = mstatus_i[3] & |({irq_i[2]&mie_i[11], irq_i[1]&mie_i[7], irq_i[0]&mie_i[3]}).
- Interrupt priority: MEI (11) > MSI (3) > MTI (7).
- IDLE arbitration, evaluated each cycle: exc_valid_i > int_en > mret_i.
- Trap accept (cycle T):
  - Latch cause: exception -> {1'b0, 26'b0, exc_cause_i}; interrupt -> {1'b1, 27'b0, code[3:0]}.
  - Latch epc: exc_pc_i for an exception, next_pc_i for an interrupt; bits [1:0] forced to 0.
  - Latch tval: exc_tval_i for an exception, 0 for an interrupt.
  - flush_o=1 and busy_o=1 combinationally in T; next state WR_MEPC.
- Write sequence:
  - T+1 WR_MEPC: we=1, addr 0x341, data epc.
  - T+2 WR_MCAUSE: we=1, addr 0x342, data cause.
  - T+3 WR_MTVAL: we=1, addr 0x343, data tval.
  - T+4 WR_MSTATUS: we=1, addr 0x300, data = mstatus_i with MPIE[7]=mstatus_i[3], MIE[3]=0, MPP[12:11]=2'b11. mstatus_i is sampled in this cycle.
  - T+5 REDIRECT: redirect_o=1, redirect_pc_o = {mtvec_i[31:2], 2'b00}; next state IDLE.
- MRET accept (cycle T): flush_o=1, busy_o=1.
  - T+1 RET_MSTATUS: we=1, addr 0x300, data = mstatus_i with MIE=MPIE, MPIE=1, MPP=2'b11.
  - T+2 REDIRECT: redirect_pc_o = {mepc_i[31:2], 2'b00}.
- busy_o is high from the accept cycle through REDIRECT inclusive. All request inputs are ignored while not in IDLE; the pipeline is flushed, so requesters do not hold them.
- csr_we_o is high only in the WR_* and RET_MSTATUS states. In all other states csr_waddr_o and csr_wdata_o are 0.
- Simultaneous events:
  - exc_valid_i and mret_i together: the exception is taken and the MRET is discarded.
  - Exception and interrupt together: the exception is taken; the interrupt remains pending and is re-evaluated in IDLE after REDIRECT.
- Back-to-back: a trap can be accepted in the first IDLE cycle after REDIRECT.
- Reset mid-sequence: return to IDLE immediately with all outputs 0. Writes already issued are not undone.

Optional Feature:
- Macro: CSR_TRAP_VECTORED_EN.
- Defined: when mtvec_i[1:0]==2'b01 and the trap is an interrupt, redirect_pc_o = {mtvec_i[31:2], 2'b00} + 4*code. Exceptions always go to the base address.
- Not defined: mtvec_i[1:0] is ignored and all traps redirect to the base address.

Test Plan:
- Exception, exc_cause_i=2, exc_pc_i=0x80, exc_tval_i=0xDEAD, mstatus_i=0x8 -> flush at T; writes 0x341=0x80, 0x342=0x2, 0x343=0xDEAD, 0x300=0x1880; redirect at T+5 to mtvec base.
- irq_i=3'b010, mie_i=0x80, mstatus_i=0x8, next_pc_i=0x104 -> mcause=0x80000007, mepc=0x104, mtval=0.
- All three irq_i lines set and enabled -> mcause=0x8000000B. Same with mstatus_i[3]=0 -> no accept, busy_o stays 0.
- mret_i with mstatus_i=0x80, mepc_i=0x203 -> write 0x300=0x1888; redirect to 0x200 at T+2.
- exc_valid_i and mret_i in the same cycle -> exception sequence only. rst_i asserted at T+2 -> all outputs 0 next edge, no further writes.
- With CSR_TRAP_VECTORED_EN, mtvec_i=0x1001, MTI taken -> redirect 0x101C. Without the macro -> redirect 0x1000.
